// File: rtl/bldc_commutator_pkg.sv
// rtl/bldc_commutator_pkg.sv - shared types and commutation lookup tables for bldc_commutator
package bldc_pkg;

  typedef logic [2:0] step_t;

  typedef enum logic [1:0] {IDLE, DEAD, RUN, FAULT} fsm_t;

  typedef enum logic [1:0] {PH_FLOAT, PH_HIGH, PH_LOW} phase_t;

  // Forward-rotation step for a hall code; invalid codes map to 0 and are gated elsewhere.
  function automatic step_t hall_to_step(input logic [2:0] h);
    step_t s;
    case (h)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  // Legs are numbered R=0, S=1, T=2.
  function automatic phase_t step_to_phase(input step_t s, input logic [1:0] leg);
    logic [1:0] hi;
    logic [1:0] lo;
    phase_t     ph;
    case (s)
      3'd0:    begin hi = 2'd0; lo = 2'd1; end
      3'd1:    begin hi = 2'd0; lo = 2'd2; end
      3'd2:    begin hi = 2'd1; lo = 2'd2; end
      3'd3:    begin hi = 2'd1; lo = 2'd0; end
      3'd4:    begin hi = 2'd2; lo = 2'd0; end
      3'd5:    begin hi = 2'd2; lo = 2'd1; end
      default: begin hi = 2'd0; lo = 2'd1; end
    endcase
    if (leg == hi)      ph = PH_HIGH;
    else if (leg == lo) ph = PH_LOW;
    else                ph = PH_FLOAT;
    return ph;
  endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// rtl/bldc_commutator_if.sv - control inputs, hall sensors and gate-driver outputs of bldc_commutator
interface bldc_commutator_if;
  logic       enable;
  logic       dir;
  logic [7:0] duty;
  logic [2:0] hall;
  logic [2:0] hin;
  logic [2:0] lin_n;
  logic [2:0] step;
  logic       hall_err;
  logic       fault;

  modport master (output enable, dir, duty, hall,
                  input  hin, lin_n, step, hall_err, fault);

  modport slave  (input  enable, dir, duty, hall,
                  output hin, lin_n, step, hall_err, fault);
endinterface

// File: rtl/bldc_commutator_hall_filter.sv
// rtl/bldc_commutator_hall_filter.sv - hall synchronizer and glitch filter (hall_filter)
module hall_filter #(
  parameter int HALL_FILT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_i,
  output logic [2:0] hall_o,
  output logic       chg_o
);
  localparam int CW = $clog2(HALL_FILT + 1);

  logic [2:0]    sync1_q, sync2_q, filt_q, filt_d, cand_q;
  logic [CW-1:0] cnt_q, cnt_d, run_len;
  logic          primed_q, primed_d, chg_q, chg_d;

  assign run_len = (sync2_q == cand_q && cnt_q != '0) ? cnt_q + CW'(1) : CW'(1);

  // Until the first value is accepted any stable code (even 000) must be able to win.
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = run_len;
    primed_d = primed_q;
    chg_d    = 1'b0;
    if (primed_q && sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (run_len == CW'(HALL_FILT)) begin
      filt_d   = sync2_q;
      cnt_d    = '0;
      primed_d = 1'b1;
      chg_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= hall_i;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cand_q   <= sync2_q;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      chg_q    <= chg_d;
    end
  end

  assign hall_o = filt_q;
  assign chg_o  = chg_q;
endmodule

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - closed-loop six-step BLDC commutator with PWM and dead time
// Optional stall detection is built when STALL_DETECT_EN is defined.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DEAD_CYC  = 27,
  parameter int HALL_FILT = 8,
`ifdef STALL_DETECT_EN
  parameter int STALL_CYC = 2700000,
`endif
  parameter int PWM_PRESC = 4
) (
  input logic              clk,
  input logic              rst_n,
  bldc_commutator_if.slave bus
);
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESC - 1);

  fsm_t          state_q, state_d;
  step_t         step_q, step_d, tgt_q, tgt_d, fwd_step, tgt;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic [2:0]    hin_q, hin_d, lin_n_q, lin_n_d, hall_filt;
  logic          hall_chg, hall_seen_q, hall_seen, hall_bad, hall_ok;
  logic          pwm_on, hall_err_q, fault_q, stall_hit;

  hall_filter #(.HALL_FILT(HALL_FILT)) u_hall_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .hall_i (bus.hall),
    .hall_o (hall_filt),
    .chg_o  (hall_chg)
  );

  assign hall_seen = hall_seen_q | hall_chg;
  assign hall_bad  = hall_seen && (hall_filt == 3'b000 || hall_filt == 3'b111);
  assign hall_ok   = hall_seen && !hall_bad;
  assign fwd_step  = hall_to_step(hall_filt);
  assign tgt       = bus.dir ? ((fwd_step >= 3'd3) ? fwd_step - 3'd3 : fwd_step + 3'd3) : fwd_step;

  // duty only reloads at the wrap so a PWM period never sees a torn compare value.
  always_comb begin
    presc_d   = presc_q + PW'(1);
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (pwm_cnt_q == 8'd254) begin
        pwm_cnt_d = 8'd0;
        duty_d    = bus.duty;
      end else begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
      end
    end
  end
  assign pwm_on = pwm_cnt_d < duty_d;

`ifdef STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYC + 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  assign stall_hit = (stall_cnt_q >= SW'(STALL_CYC - 1));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hall_chg || (state_q != RUN && state_d == RUN)) stall_cnt_d = '0;
    else if (state_q == RUN && !stall_hit)              stall_cnt_d = stall_cnt_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    hin_d      = 3'b000;
    lin_n_d    = 3'b111;
    case (state_q)
      IDLE: if (bus.enable && !fault_q && hall_ok) begin
        state_d    = DEAD;
        dead_cnt_d = '0;
        tgt_d      = tgt;
      end
      DEAD: begin
        if (hall_bad) begin
          state_d = FAULT;
        end else if (tgt != tgt_q) begin
          dead_cnt_d = '0;
          tgt_d      = tgt;
        end else if (dead_cnt_q == DEAD_LAST) begin
          state_d = RUN;
          step_d  = tgt_q;
        end else begin
          dead_cnt_d = dead_cnt_q + DW'(1);
        end
      end
      RUN: begin
        if (hall_bad || stall_hit) begin
          state_d = FAULT;
        end else if (tgt != step_q) begin
          state_d    = DEAD;
          dead_cnt_d = '0;
          tgt_d      = tgt;
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;

    if (state_d == RUN) begin
      for (int leg = 0; leg < 3; leg++) begin
        case (step_to_phase(step_d, 2'(leg)))
          PH_HIGH: hin_d[leg]   = pwm_on;
          PH_LOW:  lin_n_d[leg] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      tgt_q       <= '0;
      dead_cnt_q  <= '0;
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      hin_q       <= 3'b000;
      lin_n_q     <= 3'b111;
      hall_seen_q <= 1'b0;
      hall_err_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tgt_q       <= tgt_d;
      dead_cnt_q  <= dead_cnt_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      hin_q       <= hin_d;
      lin_n_q     <= lin_n_d;
      hall_seen_q <= hall_seen;
      hall_err_q  <= hall_bad;
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.hin      = hin_q;
  assign bus.lin_n    = lin_n_q;
  assign bus.step     = step_q;
  assign bus.hall_err = hall_err_q;
  assign bus.fault    = fault_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - self-checking bench for bldc_commutator
module tb_bldc_commutator;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bldc_commutator_if bus ();

  bldc_commutator #(
    .DEAD_CYC  (27),
    .HALL_FILT (8),
`ifdef STALL_DETECT_EN
    .STALL_CYC (60000),
`endif
    .PWM_PRESC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] fwd_hall [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  int         hi_leg   [6] = '{0, 0, 1, 1, 2, 2};
  int         lo_leg   [6] = '{1, 2, 2, 0, 0, 1};

  // Reference PWM: counter position is elapsed clocks / prescaler mod 255; duty taken every 1020 clocks.
  int         t;
  logic [7:0] duty_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t      <= 0;
      duty_m <= 8'd0;
    end else begin
      t <= t + 1;
      if ((t + 1) % 1020 == 0) duty_m <= bus.duty;
    end
  end

  int         cur_idx;
  logic       cur_dir;

  function automatic int step_of(input int idx, input logic d);
    return d ? (idx + 3) % 6 : idx;
  endfunction

  function automatic bit is_float();
    return (bus.hin == 3'b000) && (bus.lin_n == 3'b111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_run(input string tag, input int s);
    logic [2:0] eh;
    logic [2:0] el;
    el = 3'b111 & ~(3'b001 << lo_leg[s]);
    eh = (((t / 4) % 255) < int'(duty_m)) ? (3'b001 << hi_leg[s]) : 3'b000;
    chk({tag, "_step"}, bus.step, s);
    chk({tag, "_hin"}, bus.hin, eh);
    chk({tag, "_lin_n"}, bus.lin_n, el);
  endtask

  task automatic transition(output int lat, output int fl);
    lat = 0;
    fl  = 0;
    while (!is_float() && lat < 100) begin @(negedge clk); lat++; end
    while (is_float() && fl < 200) begin @(negedge clk); fl++; end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fl, n, cnt, bad, s, nh;
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.dir = 1'b0; bus.duty = 8'd255; bus.hall = 3'b101;
    cur_idx = 0; cur_dir = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hin", bus.hin, 3'b000);
    chk("rst_lin_n", bus.lin_n, 3'b111);
    chk("rst_step", bus.step, 0);
    chk("rst_hall_err", bus.hall_err, 0);
    chk("rst_fault", bus.fault, 0);

    rst_n = 1'b1;
    transition(lat, fl);
    chk("start_lat", lat, 0);
    chk("start_float", fl, 38);
    check_run("start", 0);
    repeat (1000) @(negedge clk);
    check_run("start_chop", 0);

    for (int i = 1; i <= 6; i++) begin
      cur_idx = i % 6;
      bus.hall = fwd_hall[cur_idx];
      transition(lat, fl);
      chk("fwd_lat", lat, 11);
      chk("fwd_dead", fl, 27);
      check_run("fwd", cur_idx);
    end

    cur_dir = 1'b1; bus.dir = 1'b1;
    transition(lat, fl);
    chk("rev_lat", lat, 1);
    chk("rev_dead", fl, 27);
    check_run("rev", 3);

    bus.dir = 1'b0;
    fl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (is_float()) fl++;
    end
    bus.dir = 1'b1;
    while (fl < 300) begin
      @(negedge clk);
      if (!is_float()) break;
      fl++;
    end
    chk("dead_restart", fl, 37);
    check_run("dead_restart", 3);

    for (int it = 0; it < 10; it++) begin
      bus.duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        cur_dir = ~cur_dir; bus.dir = cur_dir;
        transition(lat, fl);
        chk("rnd_dir_lat", lat, 1);
      end else begin
        nh = $urandom_range(0, 4);
        if (nh >= cur_idx) nh++;
        cur_idx = nh; bus.hall = fwd_hall[nh];
        transition(lat, fl);
        chk("rnd_hall_lat", lat, 11);
      end
      chk("rnd_dead", fl, 27);
      for (int k = 0; k < 4; k++) begin
        check_run("rnd", step_of(cur_idx, cur_dir));
        @(negedge clk);
      end
    end

    s = step_of(cur_idx, cur_dir);
    bus.duty = 8'd64;
    n = 0;
    while (duty_m != 8'd64 && n < 2100) begin @(negedge clk); n++; end
    cnt = 0; bad = 0;
    for (int i = 0; i < 1020; i++) begin
      @(negedge clk);
      if (bus.hin != 3'b000) cnt++;
      if (bus.hin != 3'b000 && bus.hin != (3'b001 << hi_leg[s])) bad++;
    end
    chk("pwm64_on", cnt, 256);
    chk("pwm64_leg", bad, 0);

    bus.duty = 8'd0;
    n = 0;
    while (duty_m != 8'd0 && n < 2100) begin @(negedge clk); n++; end
    cnt = 0;
    for (int i = 0; i < 1020; i++) begin
      @(negedge clk);
      if (bus.hin != 3'b000) cnt++;
    end
    chk("pwm0_on", cnt, 0);

    bus.hall = fwd_hall[(cur_idx + 1) % 6];
    repeat (5) @(negedge clk);
    bus.hall = fwd_hall[cur_idx];
    fl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (is_float()) fl++;
    end
    chk("glitch_float", fl, 0);
    chk("glitch_step", bus.step, s);

    bus.hall = 3'b111;
    n = 0;
    while (!bus.hall_err && n < 40) begin @(negedge clk); n++; end
    chk("err_lat", n, 11);
    chk("err_fault", bus.fault, 1);
    chk("err_hin", bus.hin, 3'b000);
    chk("err_lin_n", bus.lin_n, 3'b111);
    bus.hall = fwd_hall[cur_idx];
    repeat (20) @(negedge clk);
    chk("fault_sticky", bus.fault, 1);
    chk("err_clear", bus.hall_err, 0);
    chk("fault_float", is_float(), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("fault_cleared", bus.fault, 0);
    bus.enable = 1'b1;
    transition(lat, fl);
    chk("restart_float", fl, 28);
    check_run("restart", s);

    cur_idx = (cur_idx + 2) % 6;
    bus.hall = fwd_hall[cur_idx];
    transition(lat, fl);
    chk("pre_rst_lat", lat, 11);
    chk("pre_rst_dead", fl, 27);
    check_run("pre_rst", step_of(cur_idx, cur_dir));
    rst_n = 1'b0;
    #1;
    chk("async_rst_hin", bus.hin, 3'b000);
    chk("async_rst_lin_n", bus.lin_n, 3'b111);
    chk("async_rst_step", bus.step, 0);
    chk("async_rst_fault", bus.fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    transition(lat, fl);
    chk("rerun_float", fl, 38);
    check_run("rerun", step_of(cur_idx, cur_dir));

`ifdef STALL_DETECT_EN
    n = 0;
    while (!bus.fault && n < 61000) begin @(negedge clk); n++; end
    chk("stall_fault", bus.fault, 1);
    chk("stall_float", is_float(), 1);
`else
    cnt = 0; fl = 0;
    repeat (3000) begin
      @(negedge clk);
      if (bus.fault) cnt++;
      if (is_float()) fl++;
    end
    chk("no_stall_fault", cnt, 0);
    chk("no_stall_float", fl, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
Closed-loop six-step commutation controller for the three-phase gate-driver outputs (HIN_x / _LIN_x pairs). It samples the hall sensors, selects the commutation step and drives the gates. It chops the high side with a duty-cycle PWM and inserts dead time on every pattern change. It replaces the free-running open-loop rotate sequencer and sits between the switch/control logic and the driver pins in top.

Parameters:
DEAD_CYC, 27, clk cycles with all phases floating between gate patterns (1 us at 27 MHz)
HALL_FILT, 8, consecutive identical synchronized hall samples needed before a new hall value is accepted
PWM_PRESC, 4, clk cycles per PWM counter increment (prescaler reload = PWM_PRESC-1)
STALL_CYC, 2700000, max clk cycles between accepted hall changes in RUN (100 ms); used only with stall detect

Ports:
clk      in   1  system clock (27 MHz)
rst_n    in   1  asynchronous active-low reset
enable   in   1  run request; low = all phases float and sticky fault clears
dir      in   1  0 = forward, 1 = reverse
duty     in   8  high-side PWM duty, 0..255
hall     in   3  raw hall sensors {C,B,A}, asynchronous
hin      out  3  high-side gate {T,S,R}, active-high
lin_n    out  3  low-side gate {T,S,R}, active-low
step     out  3  current commutation step 0..5
hall_err out  1  filtered hall value is 000 or 111
fault    out  1  sticky fault

Behaviour:
- Reset values: hin=000, lin_n=111 (all phases float), step=0, hall_err=0, fault=0, FSM=IDLE, PWM counter=0.
- Phase encoding per leg:
  - high = hin 1, lin_n 1
  - low = hin 0, lin_n 0
  - float = hin 0, lin_n 1
  - hin=1 with lin_n=0 on the same leg is illegal in every cycle.
- Hall path:
  - 2-FF synchronizer, then glitch filter.
  - The filtered value updates only after HALL_FILT consecutive equal samples differing from it.
  - Latency from raw hall to filtered hall is 2+HALL_FILT cycles.
- Forward hall-to-step map: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5.
- Reverse: step = (fwd_step+3) mod 6.
- hall_err=1 for filtered 000/111; step holds its last value.
- Step pattern (high leg / low leg / float leg):
  - 0: R / S / T
  - 1: R / T / S
  - 2: S / T / R
  - 3: S / R / T
  - 4: T / R / S
  - 5: T / S / R
- PWM:
  - 8-bit counter steps 0..254 and wraps, advancing once per PWM_PRESC clk.
  - High leg's hin = (cnt < duty); duty=0 gives high side never on; duty=255 gives always on.
  - Low leg is held on for the whole step. The high leg's lin_n stays 1, so chopping needs no dead time.
  - duty is sampled at counter wrap only.
- FSM:
  - IDLE: all float. If enable=1 and fault=0 and hall_err=0, go to DEAD.
  - DEAD: all float for DEAD_CYC cycles, then latch the target step and go to RUN.
  - RUN: drive the latched pattern. A new target step (hall or dir change) goes to DEAD. enable=0 goes to IDLE. hall_err=1 sets fault and goes to FAULT.
  - FAULT: all float. enable=0 clears fault and goes to IDLE.
- Outputs are registered; a state change appears on pins on the next clk edge.
- Simultaneous events:
  - enable=0 has priority over everything.
  - Fault has priority over a step change.
  - A step change during DEAD restarts the dead counter with the newest target.
- rst_n asserted mid-operation: outputs float immediately (async); all state returns to reset values.

Optional Feature:
STALL_DETECT_EN
- Defined: a counter clears on each accepted hall change or RUN entry. Reaching STALL_CYC in RUN sets fault and goes to FAULT.
- Undefined: no counter; fault is set only by hall_err.

Decomposition:
- Package bldc_pkg holds:
  - step_t (3-bit)
  - fsm_t enum {IDLE, DEAD, RUN, FAULT}
  - phase_t enum {PH_FLOAT, PH_HIGH, PH_LOW}
  - constant hall-to-step and step-to-phase lookup functions
- One sub-module, hall_filter: synchronizer plus glitch filter, parameter HALL_FILT, outputs filtered hall and a change strobe.

Test Plan:
- Reset: rst_n low, hall=101, enable=1 -> hin=000, lin_n=111, fault=0; after release, expect 27 float cycles, then step=0, R high-side chopping, lin_n=101.
- Forward sequence: duty=255, dir=0, halls 101,100,110,010,011,001 -> step 0..5 in order; exactly 27 all-float cycles at each change; R/S/T patterns per table.
- Direction: hall=101 held, dir toggled 0->1 in RUN -> DEAD for 27 cycles, then step=3 (S high, R low).
- PWM: duty=64, PWM_PRESC=4 -> high-leg hin=1 for exactly 64*4 of every 255*4 cycles; duty=0 -> hin=000 for the whole step.
- Glitch/invalid: 5-cycle hall pulse 101->100->101 -> no step change; hall=111 held 10 cycles -> hall_err=1, fault=1, all float; enable 0->1 clears fault.
- Stall (STALL_DETECT_EN): hall frozen in RUN -> fault=1 at STALL_CYC cycles, all float; without the macro, fault stays 0.
